// File: rtl/mips_run_ctrl_if.sv
// Purpose: bundles the run-controller control/status signals between bench/core side and controller.
// Latency: n/a (wires only).
// Backpressure: none; start is a request pulse, status is level.
interface mips_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             retire_valid;
  logic [31:0]      retire_pc;
  logic             cpu_reset;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  // Bench / core side: issues start and retirement reports, observes status.
  modport master (
    output start, retire_valid, retire_pc,
    input  cpu_reset, running, done, timeout, cycle_count, instr_count
  );

  // Controller side.
  modport slave (
    input  start, retire_valid, retire_pc,
    output cpu_reset, running, done, timeout, cycle_count, instr_count
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Purpose: sequences core reset, counts RUN cycles / retirements, detects halt, end PC or watchdog.
// Latency: start -> cpu_reset low after 1+RESET_CYCLES edges; terminating retire -> done next edge.
// Backpressure: none; start is ignored while in HOLD or RUN, retire_valid ignored outside RUN.
module mips_run_ctrl #(
  parameter int          CNT_W        = 32,
  parameter int          RESET_CYCLES = 4,
  parameter int          MAX_CYCLES   = 10000,
  parameter int          HALT_REPEAT  = 3,
  parameter bit          END_EN       = 1'b0,
  parameter logic [31:0] END_PC       = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            reset,
  mips_run_ctrl_if.slave  bus
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int REP_W  = $clog2(HALT_REPEAT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(HALT_REPEAT);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    TOUT = 3'd4
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       last_pc;
  // rep_cnt == 0 means no retirement seen yet in this run, so a stale last_pc never matches.
  logic [REP_W-1:0]  rep_cnt;

  logic [CNT_W-1:0]  cyc_nxt;
  logic [CNT_W-1:0]  ins_nxt;
  logic              pc_same;
  logic [REP_W-1:0]  rep_nxt;
  logic              halt_hit;
  logic              end_hit;
  logic              term_hit;
  logic              wdog_hit;

  // Saturating increments and termination conditions for the current RUN cycle.
  always_comb begin
    cyc_nxt  = (bus.cycle_count == '1) ? bus.cycle_count : bus.cycle_count + 1'b1;
    ins_nxt  = (bus.instr_count == '1) ? bus.instr_count : bus.instr_count + 1'b1;
    pc_same  = (rep_cnt != '0) && (bus.retire_pc == last_pc);
    rep_nxt  = REP_W'(1);
    if (pc_same) begin
      rep_nxt = (rep_cnt >= REP_MAX) ? rep_cnt : rep_cnt + 1'b1;
    end
    halt_hit = bus.retire_valid && (rep_nxt >= REP_MAX);
    end_hit  = END_EN && bus.retire_valid && (bus.retire_pc == END_PC);
    term_hit = halt_hit || end_hit;
    wdog_hit = (cyc_nxt == MAX_C);
  end

  // Run-control FSM with all outputs registered; termination takes priority over the watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      last_pc         <= '0;
      rep_cnt         <= '0;
      bus.cpu_reset   <= 1'b1;
      bus.running     <= 1'b0;
      bus.done        <= 1'b0;
      bus.timeout     <= 1'b0;
      bus.cycle_count <= '0;
      bus.instr_count <= '0;
    end else begin
      case (state)
        IDLE, DONE, TOUT: begin
          if (bus.start) begin
            state           <= HOLD;
            hold_cnt        <= '0;
            rep_cnt         <= '0;
            bus.cpu_reset   <= 1'b1;
            bus.running     <= 1'b0;
            bus.done        <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.cycle_count <= '0;
            bus.instr_count <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state         <= RUN;
            bus.cpu_reset <= 1'b0;
            bus.running   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          bus.cycle_count <= cyc_nxt;
          if (bus.retire_valid) begin
            bus.instr_count <= ins_nxt;
            last_pc         <= bus.retire_pc;
            rep_cnt         <= rep_nxt;
          end
          if (term_hit) begin
            state         <= DONE;
            bus.done      <= 1'b1;
            bus.running   <= 1'b0;
            bus.cpu_reset <= 1'b1;
          end else if (wdog_hit) begin
            state         <= TOUT;
            bus.timeout   <= 1'b1;
            bus.running   <= 1'b0;
            bus.cpu_reset <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.cpu_reset <= 1'b1;
          bus.running   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Purpose: directed test of mips_run_ctrl with MAX_CYCLES=20, END_EN=1, END_PC=0x3010.
// Latency: n/a.
// Backpressure: n/a.
module tb_mips_run_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  mips_run_ctrl_if #(.CNT_W(32)) bus ();

  mips_run_ctrl #(
    .CNT_W        (32),
    .RESET_CYCLES (4),
    .MAX_CYCLES   (20),
    .HALT_REPEAT  (3),
    .END_EN       (1'b1),
    .END_PC       (32'h0000_3010)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
    check({tag, "_running"},   32'(bus.running),   32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
    check({tag, "_timeout"},   32'(bus.timeout),   32'd0);
    check({tag, "_cycles"},    bus.cycle_count,    32'd0);
    check({tag, "_instrs"},    bus.instr_count,    32'd0);
  endtask

  logic [31:0] t2_pc [5];

  initial begin
    n_chk            = 0;
    n_bad            = 0;
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.retire_valid = 1'b0;
    bus.retire_pc    = 32'h0;
    t2_pc[0] = 32'h3000;
    t2_pc[1] = 32'h3004;
    t2_pc[2] = 32'h3008;
    t2_pc[3] = 32'h3008;
    t2_pc[4] = 32'h3008;

    // T1: reset values, then start and HOLD length
    repeat (2) tick();
    check_reset_vals("rst");
    reset = 1'b1;
    tick();
    check("idle_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("idle_running",   32'(bus.running),   32'd0);

    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("hold_cpu_reset", 32'(bus.cpu_reset), 32'd1);
      check("hold_running",   32'(bus.running),   32'd0);
      tick();
    end
    check("run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("run_running",   32'(bus.running),   32'd1);
    check("run_cycles0",   bus.cycle_count,    32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("run_cycles", bus.cycle_count, 32'(i));
    end

    // T2: PC self-loop halt after three retirements at 0x3008
    for (int i = 0; i < 5; i++) begin
      bus.retire_valid = 1'b1;
      bus.retire_pc    = t2_pc[i];
      tick();
      check("t2_instrs", bus.instr_count, 32'(i + 1));
      if (i < 4) check("t2_not_done", 32'(bus.done), 32'd0);
    end
    bus.retire_valid = 1'b0;
    check("t2_done",      32'(bus.done),      32'd1);
    check("t2_running",   32'(bus.running),   32'd0);
    check("t2_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("t2_timeout",   32'(bus.timeout),   32'd0);
    check("t2_cycles",    bus.cycle_count,    32'd8);

    // retirements outside RUN are ignored and counters stay frozen
    bus.retire_valid = 1'b1;
    bus.retire_pc    = 32'h200;
    repeat (2) tick();
    bus.retire_valid = 1'b0;
    check("frz_instrs", bus.instr_count, 32'd5);
    check("frz_cycles", bus.cycle_count, 32'd8);
    check("frz_done",   32'(bus.done),   32'd1);

    // T5: restart from DONE clears everything; start during RUN is ignored
    pulse_start();
    check("t5_done",      32'(bus.done),      32'd0);
    check("t5_instrs",    bus.instr_count,    32'd0);
    check("t5_cycles",    bus.cycle_count,    32'd0);
    check("t5_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    repeat (3) tick();
    check("t5_hold_last", 32'(bus.cpu_reset), 32'd1);
    tick();
    check("t5_running",   32'(bus.running),   32'd1);
    pulse_start();
    check("t5_ign_running", 32'(bus.running),   32'd1);
    check("t5_ign_cpu_rst", 32'(bus.cpu_reset), 32'd0);
    check("t5_ign_cycles",  bus.cycle_count,    32'd1);

    // T3: watchdog at cycle_count == 20 with no retirements
    repeat (18) tick();
    check("t3_pre_timeout", 32'(bus.timeout), 32'd0);
    check("t3_pre_cycles",  bus.cycle_count,  32'd19);
    check("t3_pre_running", 32'(bus.running), 32'd1);
    tick();
    check("t3_timeout", 32'(bus.timeout), 32'd1);
    check("t3_done",    32'(bus.done),    32'd0);
    check("t3_running", 32'(bus.running), 32'd0);
    check("t3_cycles",  bus.cycle_count,  32'd20);
    repeat (3) tick();
    check("t3_frz_cycles",  bus.cycle_count,  32'd20);
    check("t3_frz_timeout", 32'(bus.timeout), 32'd1);

    // T4: fresh run ignores stale last_pc; END_PC on watchdog cycle -> done wins
    pulse_start();
    check("t4_clr_timeout", 32'(bus.timeout), 32'd0);
    repeat (4) tick();
    check("t4_running", 32'(bus.running), 32'd1);
    repeat (17) tick();
    bus.retire_valid = 1'b1;
    bus.retire_pc    = 32'h3008;
    repeat (2) tick();
    bus.retire_valid = 1'b0;
    check("t4_no_stale_done", 32'(bus.done), 32'd0);
    check("t4_cycles19",      bus.cycle_count, 32'd19);
    bus.retire_valid = 1'b1;
    bus.retire_pc    = 32'h3010;
    tick();
    bus.retire_valid = 1'b0;
    check("t4_done",    32'(bus.done),    32'd1);
    check("t4_timeout", 32'(bus.timeout), 32'd0);
    check("t4_instrs",  bus.instr_count,  32'd3);
    check("t4_cycles",  bus.cycle_count,  32'd20);

    // T6: asynchronous reset mid-RUN
    pulse_start();
    repeat (4) tick();
    bus.retire_valid = 1'b1;
    bus.retire_pc    = 32'h100;
    tick();
    bus.retire_pc    = 32'h104;
    tick();
    bus.retire_valid = 1'b0;
    check("t6_instrs", bus.instr_count, 32'd2);
    check("t6_cycles", bus.cycle_count, 32'd2);
    #3;
    reset = 1'b0;
    #1;
    check_reset_vals("t6_async");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
